// File: rtl/pattern_pkg.sv
// Shared constants for the diamond pattern generator.
// Holds the bitmap ROM, FSM states and sizing constants.
package pattern_pkg;

  localparam int ROWS               = 8;
  localparam int ROW_W              = 8;
  localparam int STEP_SCALE_DEFAULT = 16;
  localparam int CNT_W              = 12;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ROW_W-1:0] DIAMOND [ROWS] = '{
    8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18
  };

endpackage

// File: rtl/pattern_step_prescaler.sv
// Frame-step timer: raises step for one cycle every speed*STEP_SCALE enabled cycles.
// speed = 0 freezes the count; a lowered speed below the count steps at once.
module pattern_step_prescaler
  import pattern_pkg::*;
#(
  parameter int STEP_SCALE = STEP_SCALE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] speed,
  output logic       step
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] terminal;
  logic             active;

  // Period is formed at counter width, so speed=FF gives 4080.
  assign terminal = (CNT_W'(speed) * CNT_W'(STEP_SCALE)) - CNT_W'(1);
  assign active   = en && (speed != 8'd0);
  assign step     = active && (count_reg >= terminal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (active) begin
      count_reg <= step ? '0 : count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Scrolling-diamond row source for the 8x8 LED display.
// Loads rows one per cycle after reset, then refreshes all rows every cycle.
module pattern_generator
  import pattern_pkg::*;
#(
  parameter int STEP_SCALE = STEP_SCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] brightness,
  input  logic [7:0]       speed,
  output logic [ROW_W-1:0] pattern_0,
  output logic [ROW_W-1:0] pattern_1,
  output logic [ROW_W-1:0] pattern_2,
  output logic [ROW_W-1:0] pattern_3,
  output logic [ROW_W-1:0] pattern_4,
  output logic [ROW_W-1:0] pattern_5,
  output logic [ROW_W-1:0] pattern_6,
  output logic [ROW_W-1:0] pattern_7,
  output logic             pattern_valid
);

  state_t           state_reg, state_next;
  logic [2:0]       load_idx_reg;
  logic [2:0]       frame_reg;
  logic             valid_reg;
  logic             step;
  logic [ROW_W-1:0] rows_reg  [ROWS];
  logic [ROW_W-1:0] row_next  [ROWS];
  logic             row_write [ROWS];

  pattern_step_prescaler #(.STEP_SCALE(STEP_SCALE)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (state_reg == RUN),
    .speed (speed),
    .step  (step)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_idx_reg == 3'd7) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= LOAD;
      load_idx_reg <= '0;
      frame_reg    <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LOAD) begin
        load_idx_reg <= load_idx_reg + 3'd1;
        if (load_idx_reg == 3'd7) valid_reg <= 1'b1;
      end
      if (step) frame_reg <= frame_reg + 3'd1;
    end
  end

  // Row k shows DIAMOND[(k+frame) mod 8]; the 3-bit add gives the wrap.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : gen_row
      logic [2:0] rom_idx;
      assign rom_idx       = 3'(gi) + frame_reg;
      assign row_next[gi]  = DIAMOND[rom_idx] & brightness;
      assign row_write[gi] = (state_reg == RUN) || (load_idx_reg == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) rows_reg[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (row_write[i]) rows_reg[i] <= row_next[i];
      end
    end
  end

  assign pattern_0     = rows_reg[0];
  assign pattern_1     = rows_reg[1];
  assign pattern_2     = rows_reg[2];
  assign pattern_3     = rows_reg[3];
  assign pattern_4     = rows_reg[4];
  assign pattern_5     = rows_reg[5];
  assign pattern_6     = rows_reg[6];
  assign pattern_7     = rows_reg[7];
  assign pattern_valid = valid_reg;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: load sequence, masking, frame timing,
// speed change, freeze and asynchronous reset.
module tb_pattern_generator;

  logic       clk;
  logic       rst;
  logic [7:0] brightness;
  logic [7:0] speed;
  logic [7:0] pattern_0, pattern_1, pattern_2, pattern_3;
  logic [7:0] pattern_4, pattern_5, pattern_6, pattern_7;
  logic       pattern_valid;

  int total_checks;
  int failed_checks;

  pattern_generator dut (
    .clk           (clk),
    .rst           (rst),
    .brightness    (brightness),
    .speed         (speed),
    .pattern_0     (pattern_0),
    .pattern_1     (pattern_1),
    .pattern_2     (pattern_2),
    .pattern_3     (pattern_3),
    .pattern_4     (pattern_4),
    .pattern_5     (pattern_5),
    .pattern_6     (pattern_6),
    .pattern_7     (pattern_7),
    .pattern_valid (pattern_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rst        = 1'b0;
    brightness = 8'hFF;
    speed      = 8'h10;
    tick(3);
    chk("reset_p0", pattern_0, 8'h00);
    chk("reset_p7", pattern_7, 8'h00);
    chk("reset_valid", {7'd0, pattern_valid}, 8'h00);

    // Release between edges; the next edge is edge 1.
    rst = 1'b1;
    tick(2);
    $display("load: 2 edges after release");
    chk("load2_valid", {7'd0, pattern_valid}, 8'h00);
    chk("load2_p0", pattern_0, 8'h18);
    chk("load2_p1", pattern_1, 8'h3C);
    chk("load2_p2", pattern_2, 8'h00);
    chk("load2_p7", pattern_7, 8'h00);
    tick(5);
    chk("load7_valid", {7'd0, pattern_valid}, 8'h00);
    chk("load7_p7", pattern_7, 8'h00);
    chk("load7_p6", pattern_6, 8'h3C);
    tick(1);
    $display("load: edge 8");
    chk("load8_valid", {7'd0, pattern_valid}, 8'h01);
    chk("load8_p7", pattern_7, 8'h18);
    chk("load8_p3", pattern_3, 8'hFF);

    tick(4);
    $display("run: edge 12");
    chk("run12_p0", pattern_0, 8'h18);
    chk("run12_p3", pattern_3, 8'hFF);
    chk("run12_p7", pattern_7, 8'h18);
    chk("run12_valid", {7'd0, pattern_valid}, 8'h01);

    brightness = 8'h0F;
    tick(1);
    $display("mask: brightness 0F, edge 13");
    chk("mask_p0", pattern_0, 8'h08);
    chk("mask_p1", pattern_1, 8'h0C);
    chk("mask_p3", pattern_3, 8'h0F);
    brightness = 8'hFF;
    tick(1);

    // RUN begins after edge 8; frame 1 is taken at edge 264, shown at 265.
    tick(250);
    $display("step: edge 264");
    chk("step_before_p0", pattern_0, 8'h18);
    tick(1);
    $display("step: edge 265");
    chk("step_after_p0", pattern_0, 8'h3C);
    chk("step_after_p7", pattern_7, 8'h18);
    tick(1791);
    $display("wrap: edge 2056 (frame 7 shown)");
    chk("frame7_p1", pattern_1, 8'h18);
    tick(1);
    $display("wrap: edge 2057 (frame 0 shown)");
    chk("wrap_p0", pattern_0, 8'h18);
    chk("wrap_p1", pattern_1, 8'h3C);

    // Count is 100 after edge 2156; speed 05 terminal is 79, so step at once.
    tick(99);
    speed = 8'h05;
    tick(1);
    $display("speed05: edge 2157");
    chk("spd_before_p0", pattern_0, 8'h18);
    tick(1);
    $display("speed05: edge 2158");
    chk("spd_step_p0", pattern_0, 8'h3C);
    tick(79);
    chk("spd_hold_p0", pattern_0, 8'h3C);
    tick(1);
    $display("speed05: edge 2238");
    chk("spd_next_p0", pattern_0, 8'h7E);

    speed = 8'h00;
    tick(1000);
    $display("freeze: 1000 cycles at speed 0");
    chk("freeze_p0", pattern_0, 8'h7E);
    chk("freeze_p2", pattern_2, 8'hFF);
    brightness = 8'h0F;
    tick(1);
    chk("freeze_mask_p0", pattern_0, 8'h0E);
    brightness = 8'hFF;
    speed = 8'h10;
    tick(3);

    #2;
    rst = 1'b0;
    #1;
    $display("async reset mid-RUN");
    chk("arst_p0", pattern_0, 8'h00);
    chk("arst_p3", pattern_3, 8'h00);
    chk("arst_valid", {7'd0, pattern_valid}, 8'h00);
    tick(2);
    rst = 1'b1;
    tick(2);
    $display("reset release: 2 edges");
    chk("rel2_valid", {7'd0, pattern_valid}, 8'h00);
    chk("rel2_p0", pattern_0, 8'h18);
    chk("rel2_p2", pattern_2, 8'h00);
    tick(6);
    $display("reset release: 8 edges");
    chk("rel8_valid", {7'd0, pattern_valid}, 8'h01);
    chk("rel8_p0", pattern_0, 8'h18);
    chk("rel8_p7", pattern_7, 8'h18);
    tick(1);
    chk("rel9_valid", {7'd0, pattern_valid}, 8'h01);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
